cos_req_arbiter: RTL and testbench
==================================

COS_REQ_ARBITER -- requirements
Module: cos_req_arbiter

Interface
REQ-001 Parameter: TIMEOUT, 200, maximum number of WAIT cycles allowed for acc_done (range 2..255).
REQ-002 Port: clk  in  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst  in  1  reset, synchronous, active-low (rst==0 at a rising clk edge resets).
REQ-004 Port: req0_valid, req1_valid  in  1 each  requester has a job pending.
REQ-005 Port: req0_x, req1_x  in  16 each  angle operand for the job.
REQ-006 Port: req0_y, req1_y  in  8 each  term-count operand for the job.
REQ-007 Port: req0_ready, req1_ready  out  1 each  arbiter accepts the job this cycle.
REQ-008 Port: rsp0_valid, rsp1_valid  out  1 each  result available to that requester.
REQ-009 Port: rsp0_cos, rsp1_cos  out  16 each  cosine result.
REQ-010 Port: rsp0_err, rsp1_err  out  1 each  1 = job timed out, result invalid.
REQ-011 Port: rsp0_ready, rsp1_ready  in  1 each  requester consumes the response.
REQ-012 Port: acc_start  out  1  one-cycle start pulse to the cosine accelerator.
REQ-013 Port: acc_xin  out  16; acc_yin  out  8  accelerator operands.
REQ-014 Port: acc_done  in  1; acc_cos  in  16  accelerator completion and result.
REQ-015 Port: busy  out  1 (state != IDLE); grant_id  out  1  owner of the current job.

Function
REQ-016 FSM states: IDLE, ISSUE, WAIT, RESP; one job in flight at a time.
REQ-017 IDLE: requester selection is round-robin. With both valid, the requester != last_grant wins; with one valid, that one wins.
REQ-018 IDLE: readyN=1 only for the selected requester; readyN=0 in every other state.
REQ-019 Accept on validN&&readyN: latch x, y and grant_id, then go to ISSUE.
REQ-020 ISSUE: acc_start=1 for exactly one cycle; then go to WAIT; clear wait counter (8 bits).
REQ-021 acc_xin/acc_yin SHALL equal the latched operands from ISSUE through the end of WAIT; they are 0 in IDLE.
REQ-022 acc_done is sampled only in WAIT; acc_done in other states is ignored.
REQ-023 WAIT with acc_done=1: capture acc_cos and set err=0; go to RESP next cycle.
REQ-024 WAIT without acc_done: counter increments. Counter==TIMEOUT-1 without done: result=0, err=1; go to RESP.
REQ-025 acc_done in the same cycle as the timeout condition: done wins (err=0).
REQ-026 RESP: rspN_valid=1 for N=grant_id only. rspN_cos/rspN_err stay stable until rspN_ready=1.
REQ-027 RESP with rspN_ready=1: update last_grant=grant_id and go to IDLE. A new accept is possible from the next cycle.
REQ-028 rspN_cos and rspN_err are 0 whenever rspN_valid=0.
REQ-029 Latency: accept at edge T; acc_start high in cycle T+1; done sampled at edge D gives rsp_valid from cycle D+1.
REQ-030 Inputs of the non-granted requester are ignored until the next IDLE; its valid may stay high.

Reset
REQ-031 rst==0 forces: state IDLE, last_grant=1 (so requester 0 wins the first tie), counter 0, latched operands/result 0.
REQ-032 Reset values: all ready/valid/err/cos outputs 0, acc_start=0, busy=0, grant_id=0.
REQ-033 Reset mid-operation (any state) aborts the job with no response. A later acc_done is ignored unless a new job is in WAIT.

Verification
REQ-034 Single job: req0 x=16'h1000, y=8'd5; acc_done 10 cycles after start with acc_cos=16'h0F00 -> acc_start pulse of exactly 1 cycle; rsp0_valid, rsp0_cos=16'h0F00, rsp0_err=0; rsp1_valid stays 0.
REQ-035 Contention: req0 and req1 both valid from reset -> req0 is served first, then req1. A third tie after both are served -> req0 (alternation).
REQ-036 Timeout, TIMEOUT=8: acc_done never asserted -> RESP entered 8 cycles after WAIT entry; rspN_cos=0, rspN_err=1.
REQ-037 Backpressure: rsp1_ready held 0 for 5 cycles -> rsp1_valid, rsp1_cos and busy stay constant; no ready asserted; IDLE entered the cycle after rsp1_ready=1.
REQ-038 Reset mid-WAIT: rst=0 one cycle during WAIT, then a stray acc_done -> all outputs 0, no rsp_valid, state IDLE.
REQ-039 Done/timeout collision at TIMEOUT=8: acc_done asserted on the 8th WAIT cycle -> err=0 and acc_cos captured.

Source files
------------

// File: rtl/cos_req_arbiter.sv
// Two-requester round-robin front end for a single cosine accelerator.
// One job in flight; a job that never completes is answered with err=1 after TIMEOUT wait cycles.
module cos_req_arbiter #(
    parameter int TIMEOUT = 200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic        req1_valid,
    input  logic [15:0] req0_x,
    input  logic [15:0] req1_x,
    input  logic [7:0]  req0_y,
    input  logic [7:0]  req1_y,
    output logic        req0_ready,
    output logic        req1_ready,
    output logic        rsp0_valid,
    output logic        rsp1_valid,
    output logic [15:0] rsp0_cos,
    output logic [15:0] rsp1_cos,
    output logic        rsp0_err,
    output logic        rsp1_err,
    input  logic        rsp0_ready,
    input  logic        rsp1_ready,
    output logic        acc_start,
    output logic [15:0] acc_xin,
    output logic [7:0]  acc_yin,
    input  logic        acc_done,
    input  logic [15:0] acc_cos,
    output logic        busy,
    output logic        grant_id
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state;
    logic        last_grant;
    logic        gid;
    logic [15:0] x_q;
    logic [7:0]  y_q;
    logic [7:0]  cnt;
    logic [15:0] res_q;
    logic        err_q;

    logic        sel;
    logic        sel_vld;
    logic        accept;
    logic        rsp_take;
    logic        in_job;

    // On a tie the requester that was not served last wins.
    assign sel_vld  = req0_valid | req1_valid;
    assign sel      = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
    assign accept   = (state == IDLE) && sel_vld;
    assign rsp_take = gid ? rsp1_ready : rsp0_ready;
    assign in_job   = (state == ISSUE) || (state == WAIT);

    assign req0_ready = accept && !sel;
    assign req1_ready = accept && sel;

    assign acc_start = (state == ISSUE);
    assign acc_xin   = in_job ? x_q : 16'd0;
    assign acc_yin   = in_job ? y_q : 8'd0;
    assign busy      = (state != IDLE);
    assign grant_id  = gid;

    // Response fields are forced to zero for the requester that is not being answered.
    assign rsp0_valid = (state == RESP) && !gid;
    assign rsp1_valid = (state == RESP) && gid;
    assign rsp0_cos   = rsp0_valid ? res_q : 16'd0;
    assign rsp1_cos   = rsp1_valid ? res_q : 16'd0;
    assign rsp0_err   = rsp0_valid & err_q;
    assign rsp1_err   = rsp1_valid & err_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            gid        <= 1'b0;
            x_q        <= 16'd0;
            y_q        <= 8'd0;
            cnt        <= 8'd0;
            res_q      <= 16'd0;
            err_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        gid   <= sel;
                        x_q   <= sel ? req1_x : req0_x;
                        y_q   <= sel ? req1_y : req0_y;
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt   <= 8'd0;
                    state <= WAIT;
                end
                WAIT: begin
                    // A completion on the last allowed cycle still counts as success.
                    if (acc_done) begin
                        res_q <= acc_cos;
                        err_q <= 1'b0;
                        state <= RESP;
                    end else if (cnt == CNT_LAST) begin
                        res_q <= 16'd0;
                        err_q <= 1'b1;
                        state <= RESP;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                RESP: begin
                    if (rsp_take) begin
                        last_grant <= gid;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cos_req_arbiter.sv
// Directed bench: instance a uses the default timeout, instance b uses TIMEOUT=8.
module tb_cos_req_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        r0v, r1v, s0r, s1r, done;
    logic [15:0] r0x, r1x, acos;
    logic [7:0]  r0y, r1y;

    logic        a_r0rdy, a_r1rdy, a_s0v, a_s1v, a_e0, a_e1, a_start, a_busy, a_gid;
    logic [15:0] a_c0, a_c1, a_xin;
    logic [7:0]  a_yin;
    logic        b_r0rdy, b_r1rdy, b_s0v, b_s1v, b_e0, b_e1, b_start, b_busy, b_gid;
    logic [15:0] b_c0, b_c1, b_xin;
    logic [7:0]  b_yin;

    int vecs = 0;
    int miss = 0;

    always #5 clk = ~clk;

    cos_req_arbiter dut_a (
        .clk(clk), .rst(rst),
        .req0_valid(r0v), .req1_valid(r1v), .req0_x(r0x), .req1_x(r1x),
        .req0_y(r0y), .req1_y(r1y), .req0_ready(a_r0rdy), .req1_ready(a_r1rdy),
        .rsp0_valid(a_s0v), .rsp1_valid(a_s1v), .rsp0_cos(a_c0), .rsp1_cos(a_c1),
        .rsp0_err(a_e0), .rsp1_err(a_e1), .rsp0_ready(s0r), .rsp1_ready(s1r),
        .acc_start(a_start), .acc_xin(a_xin), .acc_yin(a_yin),
        .acc_done(done), .acc_cos(acos), .busy(a_busy), .grant_id(a_gid)
    );

    cos_req_arbiter #(.TIMEOUT(8)) dut_b (
        .clk(clk), .rst(rst),
        .req0_valid(r0v), .req1_valid(r1v), .req0_x(r0x), .req1_x(r1x),
        .req0_y(r0y), .req1_y(r1y), .req0_ready(b_r0rdy), .req1_ready(b_r1rdy),
        .rsp0_valid(b_s0v), .rsp1_valid(b_s1v), .rsp0_cos(b_c0), .rsp1_cos(b_c1),
        .rsp0_err(b_e0), .rsp1_err(b_e1), .rsp0_ready(s0r), .rsp1_ready(s1r),
        .acc_start(b_start), .acc_xin(b_xin), .acc_yin(b_yin),
        .acc_done(done), .acc_cos(acos), .busy(b_busy), .grant_id(b_gid)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b0; r0v = 1'b0; r1v = 1'b0; s0r = 1'b0; s1r = 1'b0; done = 1'b0;
        r0x = 16'd0; r1x = 16'd0; r0y = 8'd0; r1y = 8'd0; acos = 16'd0;
        tick(); tick();

        // reset state
        chk("rst_busy", 32'(a_busy), 0);
        chk("rst_start", 32'(a_start), 0);
        chk("rst_gid", 32'(a_gid), 0);
        chk("rst_s0v", 32'(a_s0v), 0);
        chk("rst_c0", 32'(a_c0), 0);
        chk("rst_xin", 32'(a_xin), 0);
        chk("rst_r0rdy", 32'(a_r0rdy), 0);

        // single job on requester 0, done 10 cycles after start
        rst = 1'b1; r0v = 1'b1; r0x = 16'h1000; r0y = 8'd5;
        #1;
        chk("sj_r0rdy", 32'(a_r0rdy), 1);
        chk("sj_r1rdy", 32'(a_r1rdy), 0);
        tick();
        r0v = 1'b0;
        chk("sj_start", 32'(a_start), 1);
        chk("sj_xin", 32'(a_xin), 'h1000);
        chk("sj_yin", 32'(a_yin), 5);
        chk("sj_busy", 32'(a_busy), 1);
        tick();
        chk("sj_start_1cyc", 32'(a_start), 0);
        chk("sj_xin_wait", 32'(a_xin), 'h1000);
        for (int i = 0; i < 9; i++) begin
            chk("sj_no_rsp", 32'(a_s0v), 0);
            tick();
        end
        done = 1'b1; acos = 16'h0F00;
        tick();
        done = 1'b0;
        chk("sj_s0v", 32'(a_s0v), 1);
        chk("sj_c0", 32'(a_c0), 'h0F00);
        chk("sj_e0", 32'(a_e0), 0);
        chk("sj_s1v", 32'(a_s1v), 0);
        s0r = 1'b1;
        tick();
        s0r = 1'b0;
        chk("sj_idle", 32'(a_busy), 0);
        chk("sj_c0_clr", 32'(a_c0), 0);

        // contention from reset, then backpressure on requester 1
        rst = 1'b0; tick(); rst = 1'b1;
        r0v = 1'b1; r1v = 1'b1; r0x = 16'h0111; r1x = 16'h0222;
        #1;
        chk("ct_r0rdy", 32'(a_r0rdy), 1);
        chk("ct_r1rdy", 32'(a_r1rdy), 0);
        tick();
        chk("ct_gid0", 32'(a_gid), 0);
        chk("ct_xin0", 32'(a_xin), 'h0111);
        tick();
        done = 1'b1; acos = 16'h1111;
        tick();
        done = 1'b0;
        chk("ct_s0v", 32'(a_s0v), 1);
        chk("ct_c0", 32'(a_c0), 'h1111);
        s0r = 1'b1;
        tick();
        s0r = 1'b0;
        chk("ct_r1rdy2", 32'(a_r1rdy), 1);
        chk("ct_r0rdy2", 32'(a_r0rdy), 0);
        tick();
        chk("ct_gid1", 32'(a_gid), 1);
        chk("ct_xin1", 32'(a_xin), 'h0222);
        tick();
        done = 1'b1; acos = 16'h2222;
        tick();
        done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_s1v", 32'(a_s1v), 1);
            chk("bp_c1", 32'(a_c1), 'h2222);
            chk("bp_s0v", 32'(a_s0v), 0);
            chk("bp_busy", 32'(a_busy), 1);
            chk("bp_r0rdy", 32'(a_r0rdy), 0);
            chk("bp_r1rdy", 32'(a_r1rdy), 0);
            tick();
        end
        s1r = 1'b1;
        tick();
        s1r = 1'b0;
        chk("bp_idle", 32'(a_busy), 0);
        chk("ct_tie3_r0", 32'(a_r0rdy), 1);
        chk("ct_tie3_r1", 32'(a_r1rdy), 0);
        r0v = 1'b0; r1v = 1'b0;

        // timeout on instance b, requester 1
        rst = 1'b0; tick(); rst = 1'b1;
        r1v = 1'b1; r1x = 16'h0333; r1y = 8'd7;
        #1;
        chk("to_r1rdy", 32'(b_r1rdy), 1);
        tick();
        r1v = 1'b0;
        chk("to_start", 32'(b_start), 1);
        tick();
        for (int i = 0; i < 8; i++) begin
            chk("to_wait_s1v", 32'(b_s1v), 0);
            chk("to_wait_xin", 32'(b_xin), 'h0333);
            chk("to_wait_busy", 32'(b_busy), 1);
            tick();
        end
        chk("to_s1v", 32'(b_s1v), 1);
        chk("to_e1", 32'(b_e1), 1);
        chk("to_c1", 32'(b_c1), 0);
        s1r = 1'b1;
        tick();
        s1r = 1'b0;
        chk("to_idle", 32'(b_busy), 0);
        chk("to_e1_clr", 32'(b_e1), 0);

        // done on the 8th wait cycle beats the timeout
        r0v = 1'b1; r0x = 16'h0444;
        tick();
        r0v = 1'b0;
        tick();
        for (int i = 0; i < 7; i++) tick();
        chk("co_still_wait", 32'(b_s0v), 0);
        done = 1'b1; acos = 16'h0ABC;
        tick();
        done = 1'b0;
        chk("co_s0v", 32'(b_s0v), 1);
        chk("co_e0", 32'(b_e0), 0);
        chk("co_c0", 32'(b_c0), 'h0ABC);
        s0r = 1'b1;
        tick();
        s0r = 1'b0;

        // reset during WAIT, then a stray done
        rst = 1'b0; tick(); rst = 1'b1;
        r0v = 1'b1; r0x = 16'h0555;
        tick();
        r0v = 1'b0;
        tick(); tick(); tick();
        chk("rw_in_wait", 32'(a_busy), 1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("rw_busy", 32'(a_busy), 0);
        chk("rw_xin", 32'(a_xin), 0);
        chk("rw_gid", 32'(a_gid), 0);
        done = 1'b1; acos = 16'hFFFF;
        tick();
        done = 1'b0;
        chk("rw_s0v", 32'(a_s0v), 0);
        chk("rw_s1v", 32'(a_s1v), 0);
        chk("rw_c0", 32'(a_c0), 0);
        chk("rw_start", 32'(a_start), 0);
        tick();
        chk("rw_busy2", 32'(a_busy), 0);
        chk("rw_s0v2", 32'(a_s0v), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
